// File: rtl/memory_arbiter.sv
// Shares one main-memory port between icache (I) and dcache (D); one line transaction at a time.
// Optional macro ARBITER_ROUND_ROBIN_EN: alternate grants on ties instead of fixed D-over-I priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_req,
  input  logic                  i_op,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_data_in,
  output logic [LINE_WIDTH-1:0] i_data_out,
  output logic                  i_done,
  output logic                  i_busy,

  input  logic                  d_req,
  input  logic                  d_op,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_data_in,
  output logic [LINE_WIDTH-1:0] d_data_out,
  output logic                  d_done,
  output logic                  d_busy,

  output logic                  mem_enable,
  output logic                  mem_op_init,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  output logic                  mem_op_done,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  input  logic                  mem_memory_in_use,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state, state_nxt;
  logic       owner_is_d;
  logic [7:0] count;
  logic       grant, grant_d;
  logic       complete, expire;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= 1'b0;
    else if (grant)
      last_grant <= grant_d;
  end
`endif

  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    if (state == S_IDLE && !mem_memory_in_use && (i_req || d_req)) begin
      grant = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
      if (i_req && d_req)
        grant_d = ~last_grant;
      else
        grant_d = d_req;
`else
      grant_d = d_req;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE:    if (grant) state_nxt = S_WAIT;
      S_WAIT: begin
        // Memory completion wins over a timeout landing on the same edge.
        if (mem_data_ready) begin
          complete  = 1'b1;
          state_nxt = S_RELEASE;
        end else if (count == TIMEOUT_LIMIT) begin
          expire    = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner_is_d  <= 1'b0;
      count       <= '0;
      mem_enable  <= 1'b0;
      mem_op_init <= 1'b0;
      mem_op      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_op_done <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_data_out  <= '0;
      d_data_out  <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_op_init <= grant;
      mem_op_done <= complete | expire;
      i_done      <= (complete | expire) & ~owner_is_d;
      d_done      <= (complete | expire) & owner_is_d;

      if (grant) begin
        owner_is_d  <= grant_d;
        mem_op      <= grant_d ? d_op      : i_op;
        mem_address <= grant_d ? d_address : i_address;
        mem_data_in <= grant_d ? d_data_in : i_data_in;
        mem_enable  <= 1'b1;
        count       <= '0;
      end else if (state == S_WAIT) begin
        if (complete || expire) begin
          mem_enable <= 1'b0;
          count      <= '0;
        end else begin
          count <= count + 8'd1;
        end
      end

      if (expire)
        timeout <= 1'b1;

      if (complete && !mem_op) begin
        if (owner_is_d)
          d_data_out <= mem_data_out;
        else
          i_data_out <= mem_data_out;
      end
    end
  end

  // The non-owner is told to wait from grant until the turnaround cycle ends.
  always_comb begin
    i_busy = 1'b0;
    d_busy = 1'b0;
    if (state == S_WAIT || state == S_RELEASE) begin
      i_busy = owner_is_d;
      d_busy = ~owner_is_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected transactions queued at request time, checked at grant and done.
module tb_memory_arbiter;
  localparam int AW = 12;
  localparam int LW = 128;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0, i_op = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_data_in = '0;
  logic [LW-1:0] i_data_out;
  logic          i_done, i_busy;
  logic          d_req = 1'b0, d_op = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_data_in = '0;
  logic [LW-1:0] d_data_out;
  logic          d_done, d_busy;
  logic          mem_enable, mem_op_init, mem_op, mem_op_done, timeout;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic [LW-1:0] mem_data_out = '0;
  logic          mem_data_ready = 1'b0;
  logic          mem_memory_in_use = 1'b0;

  memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_op(i_op), .i_address(i_address), .i_data_in(i_data_in),
    .i_data_out(i_data_out), .i_done(i_done), .i_busy(i_busy),
    .d_req(d_req), .d_op(d_op), .d_address(d_address), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done), .d_busy(d_busy),
    .mem_enable(mem_enable), .mem_op_init(mem_op_init), .mem_op(mem_op),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_op_done(mem_op_done),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
    .mem_memory_in_use(mem_memory_in_use), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            port;   // 1 = D
    bit            op;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            dead;   // memory never answers
  } txn_t;

  txn_t          exp_q[$];
  txn_t          cur;
  bit            cur_vld = 0;
  bit            exp_lg = 0;
  logic [LW-1:0] i_model = '0, d_model = '0;
  int            passed = 0, total = 0;
  int            mem_lat = 3;
  int            done_cnt = 0;
  int            cyc = 0, init_cyc = 0, wcnt = 0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 20'h0, a, 32'hCAFEF00D, 20'h0, a};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic req(input bit port, input bit op, input logic [AW-1:0] a,
                     input logic [LW-1:0] w, input bit dead);
    txn_t t;
    t.port = port; t.op = op; t.addr = a; t.wdata = w; t.dead = dead;
    exp_q.push_back(t);
    exp_lg = port;
    if (port) begin d_req = 1'b1; d_op = op; d_address = a; d_data_in = w; end
    else      begin i_req = 1'b1; i_op = op; i_address = a; i_data_in = w; end
  endtask

  task automatic tie();
    bit first;
`ifdef ARBITER_ROUND_ROBIN_EN
    first = ~exp_lg;
`else
    first = 1'b1;
`endif
    req(first, 1'b0, first ? 12'h020 : 12'h010, '0, 1'b0);
    req(~first, 1'b0, first ? 12'h010 : 12'h020, '0, 1'b0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check(tag, LW'(exp_q.size()), '0);
    if (exp_q.size() != 0) begin
      exp_q.delete(); cur_vld = 0; i_req = 1'b0; d_req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory model: answers mem_lat cycles after the start pulse; mem_lat = 0 means never.
  initial begin
    forever begin
      @(negedge clk);
      mem_data_ready = 1'b0;
      if (mem_op_init) wcnt = 0;
      else if (mem_enable) wcnt++;
      if (reset && mem_enable && mem_lat != 0 && wcnt == mem_lat) begin
        mem_data_ready = 1'b1;
        mem_data_out   = line_of(mem_address);
      end
    end
  end

  // Monitor: checks each grant against the queue head and each done against the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) continue;
      if (mem_op_init) begin
        if (exp_q.size() == 0) check("spurious_grant", LW'(1), LW'(0));
        else begin
          cur = exp_q[0]; cur_vld = 1; init_cyc = cyc;
          check("grant_owner", LW'({i_busy, d_busy}), LW'(cur.port ? 2'b10 : 2'b01));
          check("grant_addr", LW'(mem_address), LW'(cur.addr));
          check("grant_op", LW'(mem_op), LW'(cur.op));
          check("grant_enable", LW'(mem_enable), LW'(1));
          if (cur.op) check("grant_wdata", mem_data_in, cur.wdata);
        end
      end else if (mem_enable && cur_vld && cur.op) begin
        check("wait_addr_stable", LW'(mem_address), LW'(cur.addr));
        check("wait_wdata_stable", mem_data_in, cur.wdata);
        check("wait_op_stable", LW'(mem_op), LW'(1));
      end
      if (i_done || d_done) begin
        done_cnt++;
        if (!cur_vld) check("spurious_done", LW'(1), LW'(0));
        else begin
          void'(exp_q.pop_front());
          cur_vld = 0;
          check("done_port", LW'({i_done, d_done}), LW'(cur.port ? 2'b01 : 2'b10));
          check("done_op_done", LW'(mem_op_done), LW'(1));
          check("done_enable_low", LW'(mem_enable), LW'(0));
          check("done_latency", LW'(cyc - init_cyc), LW'(cur.dead ? TO + 1 : mem_lat + 1));
          if (cur.port) begin
            if (!cur.op && !cur.dead) d_model = line_of(cur.addr);
            check("d_data_out", d_data_out, d_model);
            d_req = 1'b0;
          end else begin
            if (!cur.op && !cur.dead) i_model = line_of(cur.addr);
            check("i_data_out", i_data_out, i_model);
            i_req = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #1;
    check("rst_enable", LW'(mem_enable), '0);
    check("rst_init", LW'(mem_op_init), '0);
    check("rst_busy", LW'({i_busy, d_busy}), '0);
    check("rst_i_data", i_data_out, '0);
    check("rst_timeout", LW'(timeout), '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single icache read with a 3-cycle memory
    mem_lat = 3; d0 = done_cnt;
    req(1'b0, 1'b0, 12'h004, '0, 1'b0);
    @(negedge clk);
    check("t1_init", LW'(mem_op_init), LW'(1));
    check("t1_addr", LW'(mem_address), LW'(12'h004));
    check("t1_d_busy", LW'(d_busy), LW'(1));
    check("t1_i_busy", LW'(i_busy), '0);
    drain("t1_drain", 40);
    check("t1_done_once", LW'(done_cnt - d0), LW'(1));
    check("t1_line", i_data_out, line_of(12'h004));

    // Two back-to-back ties
    tie();
    drain("tie1_drain", 60);
    tie();
    drain("tie2_drain", 60);

    // dcache write, with requester inputs disturbed and req dropped mid-WAIT
    mem_lat = 4; d0 = done_cnt;
    req(1'b1, 1'b1, 12'h0A0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    repeat (2) @(negedge clk);
    d_address = 12'hFFF; d_data_in = '1; d_op = 1'b0; d_req = 1'b0;
    drain("wr_drain", 40);
    check("wr_done_once", LW'(done_cnt - d0), LW'(1));
    check("wr_d_data_kept", d_data_out, line_of(12'h020));

    // Memory busy holds off the grant
    mem_lat = 3;
    mem_memory_in_use = 1'b1;
    req(1'b0, 1'b0, 12'h123, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("inuse_hold", LW'(mem_op_init), '0);
    end
    mem_memory_in_use = 1'b0;
    @(negedge clk);
    check("inuse_release_grant", LW'(mem_op_init), LW'(1));
    drain("inuse_drain", 40);

    // Memory never answers: timeout
    mem_lat = 0; d0 = done_cnt;
    req(1'b0, 1'b0, 12'h0F0, '0, 1'b1);
    repeat (10) @(negedge clk);
    check("to_not_yet", LW'(timeout), '0);
    drain("to_drain", 400);
    check("to_flag", LW'(timeout), LW'(1));
    check("to_done_once", LW'(done_cnt - d0), LW'(1));
    mem_lat = 2;
    req(1'b1, 1'b0, 12'h033, '0, 1'b0);
    drain("to_after_drain", 40);
    check("to_sticky", LW'(timeout), LW'(1));

    // Reset mid-WAIT
    mem_lat = 0;
    req(1'b0, 1'b0, 12'h055, '0, 1'b1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_enable", LW'(mem_enable), '0);
    check("arst_addr", LW'(mem_address), '0);
    check("arst_op_done", LW'(mem_op_done), '0);
    check("arst_busy", LW'({i_busy, d_busy}), '0);
    check("arst_d_data", d_data_out, '0);
    check("arst_timeout", LW'(timeout), '0);
    exp_q.delete(); cur_vld = 0; i_req = 1'b0; d_req = 1'b0;
    i_model = '0; d_model = '0; exp_lg = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst_no_done", LW'({i_done, d_done, mem_op_done}), '0);
    end
    reset = 1'b1;
    mem_lat = 2;
    req(1'b0, 1'b0, 12'h066, '0, 1'b0);
    @(negedge clk);
    check("post_rst_init", LW'(mem_op_init), LW'(1));
    drain("post_rst_drain", 40);
    check("post_rst_line", i_data_out, line_of(12'h066));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (port I) and the data cache (port D).
- Sits between both caches and the Memory block.
- Accepts one line-sized request at a time, drives the memory handshake and returns the line or write completion to the owner only.
- Holds off the other requester until the transaction has completed.

Parameters:
ADDR_WIDTH, 12, memory line address width
LINE_WIDTH, 128, cache line width in bits
TIMEOUT_CYCLES, 255, max cycles waiting for mem_data_ready before abort (8-bit counter)

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  asynchronous, active-low reset
i_req  in  1  icache request; level, held until i_done
i_op  in  1  0 = read line, 1 = write line
i_address  in  ADDR_WIDTH  icache line address
i_data_in  in  LINE_WIDTH  icache write data
i_data_out  out  LINE_WIDTH  line returned to icache
i_done  out  1  one-cycle completion pulse to icache
i_busy  out  1  memory owned by D (icache must wait)
d_req, d_op, d_address, d_data_in, d_data_out, d_done, d_busy  as above, for dcache
mem_enable  out  1  memory enable, high for the whole transaction
mem_op_init  out  1  one-cycle start pulse
mem_op  out  1  forwarded op of owner
mem_address  out  ADDR_WIDTH  forwarded address
mem_data_in  out  LINE_WIDTH  forwarded write data
mem_op_done  out  1  one-cycle release pulse to memory
mem_data_out  in  LINE_WIDTH  memory read data
mem_data_ready  in  1  memory completion
mem_memory_in_use  in  1  memory not ready to accept
timeout  out  1  sticky error flag

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE, owner = none, last_grant = I.
  - All outputs 0, including data_out registers, timeout and the counter.
  - A reset mid-transaction aborts it silently: no done pulse and no mem_op_done.
- State IDLE:
  - Grant only if mem_memory_in_use = 0 and at least one req = 1.
  - On a grant, at the next edge: latch owner, op, address and data into registers; pulse mem_op_init; set mem_enable; go to WAIT.
- Arbitration with both requests high: fixed priority, D wins.
- Latency: req sampled high at edge t makes mem_op_init high in cycle t+1.
- mem_op, mem_address and mem_data_in come from the latched registers and stay stable through WAIT, independent of requester inputs.
- State WAIT:
  - Counter increments every cycle.
  - On mem_data_ready = 1 at an edge:
    - Read (op = 0): copy mem_data_out into the owner's data_out.
    - Write: owner's data_out unchanged.
    - Pulse the owner's done and mem_op_done for one cycle; drop mem_enable; go to RELEASE.
  - On counter = TIMEOUT_CYCLES with no ready: set timeout (sticky), pulse the owner's done with data_out unchanged, pulse mem_op_done, go to RELEASE.
- State RELEASE: one idle turnaround cycle, no grant, then IDLE.
  - A req still high in IDLE is a new request; requesters drop req in the cycle they see done.
- busy signals: x_busy = 1 while the other port owns the memory (WAIT or RELEASE); 0 in IDLE.
- Request changes: a requester dropping req during WAIT does not cancel the transaction; done is still pulsed.
- data_out: holds its value until the next read completion for that port.
- Stall interplay: done gates the pipeline the way icache completion gates rm0 update; the non-owner sees busy.

Optional Feature:
- Macro ARBITER_ROUND_ROBIN_EN.
- Defined: on a tie, grant the port not equal to last_grant; last_grant updates on every grant. last_grant resets to I, so the first tie goes to D.
- Undefined: fixed D-over-I priority; last_grant is not implemented.
- Single-request behaviour is identical either way.

Test Plan:
- Reset deasserted, i_req = 1, i_op = 0, i_address = 0x004; memory returns 0xDEADBEEF_... after 3 cycles:
  - mem_op_init pulses the cycle after req; mem_address = 0x004.
  - i_done pulses once; i_data_out = the line; d_busy high during WAIT.
- i_req and d_req both raised in the same cycle:
  - Fixed build: D served first, then I after RELEASE.
  - With ARBITER_ROUND_ROBIN_EN, two back-to-back ties: grants D, I, D.
- d_req write (d_op = 1, d_data_in = 0x0123..., d_address = 0x0A0):
  - mem_op = 1 and mem_data_in forwarded and stable through WAIT.
  - d_data_out unchanged; d_done pulses.
- mem_memory_in_use = 1 with i_req = 1 for 5 cycles: no mem_op_init. After release, grant occurs the next cycle.
- mem_data_ready never asserted: after 255 WAIT cycles, timeout = 1 (stays 1), owner done pulses once, mem_op_done pulses.
- reset pulled low during WAIT: all outputs 0 asynchronously, no done pulse; after release, arbiter idle and a new request is served normally.
